// File: rtl/uart_word_loader.sv
// uart_word_loader: packs WORD_BYTES received UART bytes into one word and
// hands each word to the memory writer over a req/ack port. Each word goes
// to the next word address.
// Optional build macro LOAD_TIMEOUT_EN adds an inter-byte timeout. When it
// expires, the partial word is discarded and the timeout port pulses.
module uart_word_loader #(
  parameter int WORD_BYTES     = 2,
  parameter int ADDR_WIDTH     = 16,
  parameter bit MSB_FIRST      = 1'b0,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_en,
  input  logic                    clr,
  input  logic [7:0]              byte_data,
  input  logic                    byte_valid,
  output logic [8*WORD_BYTES-1:0] word_data,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic                    wr_req,
  input  logic                    wr_ack,
  output logic [ADDR_WIDTH:0]     word_count,
  output logic                    partial,
  output logic                    overrun,
  output logic                    full
`ifdef LOAD_TIMEOUT_EN
  , output logic                  timeout
`endif
);

  localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);
  localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

`ifdef LOAD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  logic [IDX_W-1:0]        index;
  logic [IDX_W-1:0]        lane;
  logic [8*WORD_BYTES-1:0] shift_reg;
  logic [8*WORD_BYTES-1:0] assembled;
  logic [ADDR_WIDTH:0]     count_next;
  logic                    accept;
  logic                    complete;
  logic                    ack_now;
  logic                    room;
  logic                    issue;
  logic                    drop;

  assign partial = (index != '0);
  assign full    = (word_count == CAPACITY);

  // Decide this cycle's byte acceptance, word completion and write outcome.
  // count_next already includes an ack that lands in this cycle. A word
  // issued back-to-back with that ack therefore takes the following
  // address. If that address would run past the last word, the word is
  // dropped silently instead of wrapping.
  always_comb begin
    accept     = byte_valid & load_en & ~full;
    complete   = accept & (index == LAST_IDX);
    ack_now    = wr_req & wr_ack;
    count_next = word_count + (ADDR_WIDTH+1)'(ack_now);
    room       = (count_next != CAPACITY);
    issue      = complete & (~wr_req | wr_ack) & room;
    drop       = complete & wr_req & ~wr_ack;
    lane       = MSB_FIRST ? (LAST_IDX - index) : index;
    assembled  = shift_reg;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (lane == IDX_W'(i)) begin
        assembled[i*8 +: 8] = byte_data;
      end
    end
  end

  // Byte assembly, write handshake, word counting and sticky flags.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_req     <= 1'b0;
      word_data  <= '0;
      wr_addr    <= '0;
      word_count <= '0;
      overrun    <= 1'b0;
      index      <= '0;
      shift_reg  <= '0;
`ifdef LOAD_TIMEOUT_EN
      tmo_cnt    <= '0;
      timeout    <= 1'b0;
`endif
    end else begin
      if (ack_now) begin
        word_count <= count_next;
      end

      if (issue) begin
        word_data <= assembled;
        wr_addr   <= count_next[ADDR_WIDTH-1:0];
        wr_req    <= 1'b1;
      end else if (ack_now) begin
        wr_req <= 1'b0;
      end

      if (drop) begin
        overrun <= 1'b1;
      end

      if (accept) begin
        shift_reg <= assembled;
        index     <= (index == LAST_IDX) ? '0 : index + 1'b1;
      end else if (!load_en) begin
        index <= '0;
`ifdef LOAD_TIMEOUT_EN
      end else if (partial && (tmo_cnt == TMO_LIMIT)) begin
        index <= '0;
`endif
      end

`ifdef LOAD_TIMEOUT_EN
      timeout <= 1'b0;
      if (accept || !load_en || !partial) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt == TMO_LIMIT) begin
        tmo_cnt <= '0;
        timeout <= 1'b1;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
`endif
    end
  end

endmodule
